wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Round-robin arbiter sharing the register-file write port between six writeback sources. It sits between the writeback requesters and the 6-to-1 write-data mux. Each cycle it picks at most one pending requester, drives the mux select and the register-file write enable, and returns a one-cycle grant. Arbitration is registered, so the selected data path is stable for the whole write cycle.

## Interface
Parameters
- `NUM_REQ`, 6: number of requesters; fixed by the 6-input mux, not overridable.
- `SEL_W`, 3: select width.

Ports
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  6  per-source write request; bit i maps to mux input i (0: ALU, 1: load data, 2: LUI, 3: shifter, 4: HI, 5: LO).
- `stall`  in  1  control-unit freeze; no new grant while high.
- `flush`  in  1  cancel any grant being issued next cycle.
- `sel`  out  3  write-data mux select, binary 0..5.
- `gnt`  out  6  one-hot grant, high for exactly one cycle.
- `reg_write`  out  1  register-file write enable; equals `|gnt`.
- `busy`  out  1  high when any unmasked `req` bit is pending and no grant is issued this cycle.

## Operation
- FSM states:
  - IDLE: no grant this cycle.
  - GRANT: `gnt`/`reg_write` high this cycle.
  - HOLD: stall in effect.
- Transitions, evaluated each rising edge, first match wins:
  - `flush`=1: go to IDLE.
  - `stall`=1: go to HOLD.
  - Eligible request exists: go to GRANT.
  - Otherwise: go to IDLE.
- Eligible set: `req & ~gnt`. The index granted this cycle is masked from the next arbitration, so a requester has one cycle to drop `req` after seeing `gnt`.
- Round-robin pointer `ptr` (3 bits, 0..5):
  - Search order is ptr, ptr+1, …, 5, 0, …, ptr-1.
  - The first eligible index i wins.
  - On entering GRANT, `ptr` becomes i+1, with 5 wrapping to 0.
  - `ptr` is unchanged on IDLE, HOLD and flush.
- On entering GRANT: `gnt` = one-hot(i), `sel` = i, `reg_write` = 1.
- Outside GRANT:
  - `gnt` = 0 and `reg_write` = 0.
  - `sel` holds its last granted value, to avoid needless mux toggling.
- `sel` never takes values 6 or 7.
- Requesters must hold `req` until granted. A `req` dropped before grant is simply no longer eligible; no error is raised.

## Timing
- Reset values (asynchronous, on `reset`=0): state IDLE, `ptr`=0, `sel`=3'b000, `gnt`=0, `reg_write`=0, `busy`=0.
- Latency:
  - `req` sampled high at edge N produces `gnt`/`reg_write` during cycle N+1 (one cycle).
  - `sel` is valid in the same cycle as `gnt`.
- Throughput: one grant per cycle with back-to-back grants to different requesters. The same requester can be re-granted no sooner than 2 cycles apart.
- `stall`:
  - High at an edge suppresses the grant for the following cycle.
  - A grant already visible in the current cycle completes normally.
- `flush` and `stall` both high: flush wins, next state IDLE.
- `busy` is combinational from the registered state and `req`. It is low in any cycle where `gnt` is high.
- Reset mid-grant:
  - `gnt`/`reg_write` fall asynchronously with `reset`.
  - No partial write is guaranteed beyond the register file's own edge.
- Release from reset: first grant no earlier than the second rising edge after `reset` deasserts.

## Structure
- Shared package holds:
  - Requester index constants: `WB_ALU`=0, `WB_MEM`=1, `WB_LUI`=2, `WB_SHIFT`=3, `WB_HI`=4, `WB_LO`=5.
  - The FSM state encoding: IDLE=2'b00, GRANT=2'b01, HOLD=2'b10.
  - `NUM_REQ`/`SEL_W`.
- One natural sub-module: `rr_pick6`, a purely combinational block. It takes the 6-bit eligible vector and the 3-bit `ptr` and returns `found` and the 3-bit winner index.
- The top level keeps the FSM, `ptr` and the output registers.

## Test plan
- Reset: with `reset`=0, `req`=6'b111111 → `sel`=0, `gnt`=0, `reg_write`=0. After release, the first grant is `gnt`=6'b000001, then `ptr`=1.
- Single request: `req`=6'b001000 at edge N → cycle N+1 `gnt`=6'b001000, `sel`=3, `reg_write`=1. Then `req` drops and the FSM returns to IDLE with `sel` still 3.
- Fairness/wrap: `req`=6'b100001 held continuously from `ptr`=5 → grants alternate 5,0,5,0. `sel` sequence is 5,0,5,0, with no cycle in which both bits are granted.
- Stall: requests pending, `stall`=1 for 3 cycles → `gnt`=0 and `ptr` frozen for those cycles. The first grant appears the cycle after `stall` falls.
- Flush + stall: `req`=6'b000010, `flush`=1 and `stall`=1 at the same edge → next cycle state IDLE, `gnt`=0, `ptr` unchanged. The grant to index 1 follows one cycle later.
- Async reset mid-grant: assert `reset` while `gnt`=6'b010000 → `gnt` and `reg_write` fall immediately, before the next clock edge, and `ptr` returns to 0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the writeback-port round-robin arbiter:
// requester indices, FSM encoding and pointer arithmetic helpers.
package wb_port_arbiter_pkg;

    localparam int unsigned NUM_REQ = 6;
    localparam int unsigned SEL_W   = 3;

    localparam logic [SEL_W-1:0] WB_ALU   = 3'd0;
    localparam logic [SEL_W-1:0] WB_MEM   = 3'd1;
    localparam logic [SEL_W-1:0] WB_LUI   = 3'd2;
    localparam logic [SEL_W-1:0] WB_SHIFT = 3'd3;
    localparam logic [SEL_W-1:0] WB_HI    = 3'd4;
    localparam logic [SEL_W-1:0] WB_LO    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_HOLD  = 2'b10
    } wb_state_e;

    // Index reached by stepping offs places from base, wrapping modulo NUM_REQ.
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base,
                                                  input int unsigned      offs);
        int unsigned sum;
        sum = (32'(base) + offs) % NUM_REQ;
        return sum[SEL_W-1:0];
    endfunction

    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
        return (idx == WB_LO) ? WB_ALU : idx + 3'd1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Request/grant bundle between the writeback sources, the control unit
// and the arbiter; slave is the arbiter side.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               stall;
    logic               flush;
    logic [SEL_W-1:0]   sel;
    logic [NUM_REQ-1:0] gnt;
    logic               reg_write;
    logic               busy;

    modport master (
        output req, stall, flush,
        input  sel, gnt, reg_write, busy
    );

    modport slave (
        input  req, stall, flush,
        output sel, gnt, reg_write, busy
    );

endinterface

// File: rtl/rr_pick6.sv
// Combinational round-robin picker: first set bit of i_elig searching
// upward from i_ptr with wrap at NUM_REQ.
module rr_pick6
    import wb_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [SEL_W-1:0]   o_idx
);

    logic [7:0] w_elig8;

    assign w_elig8 = {2'b00, i_elig};

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!o_found && w_elig8[rr_index(i_ptr, k)]) begin
                o_found = 1'b1;
                o_idx   = rr_index(i_ptr, k);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Registered round-robin arbiter for the register-file write port,
// shared by six writeback sources.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);

    wb_state_e          r_state;
    wb_state_e          w_next_state;
    logic               r_armed;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_gnt;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;

    // The index granted this cycle sits out the next arbitration.
    assign w_elig = bus.req & ~r_gnt;

    rr_pick6 u_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_next_state = ST_IDLE;
        w_gnt_nxt    = '0;
        w_sel_nxt    = r_sel;
        w_ptr_nxt    = r_ptr;
        if (bus.flush) begin
            w_next_state = ST_IDLE;
        end else if (bus.stall) begin
            w_next_state = ST_HOLD;
        end else if (r_armed && w_found) begin
            w_next_state = ST_GRANT;
            w_gnt_nxt    = NUM_REQ'(1) << w_idx;
            w_sel_nxt    = w_idx;
            w_ptr_nxt    = next_ptr(w_idx);
        end
    end

    // r_armed delays the first grant to the second edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_armed <= 1'b1;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.reg_write = (r_state == ST_GRANT);
    assign bus.busy      = reset && (|bus.req) && (r_state != ST_GRANT);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset/release sequence, a vector
// table covering grant, masking, wrap, stall and flush, and async reset.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wb_port_arbiter_if u_if ();

    wb_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    typedef struct {
        logic [5:0] req;
        logic       stall;
        logic       flush;
        logic [5:0] gnt;
        logic [2:0] sel;
        logic       rw;
        logic       busy;
        logic [2:0] ptr;
    } vec_t;

    vec_t vecs [23];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [5:0] gnt, input logic [2:0] sel,
                           input logic rw, input logic busy, input logic [2:0] ptr);
        chk({tag, " gnt"},  32'(u_if.gnt),       32'(gnt));
        chk({tag, " sel"},  32'(u_if.sel),       32'(sel));
        chk({tag, " rw"},   32'(u_if.reg_write), 32'(rw));
        chk({tag, " busy"}, 32'(u_if.busy),      32'(busy));
        chk({tag, " ptr"},  32'(dut.r_ptr),      32'(ptr));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //          req        st    fl    gnt        sel   rw    busy  ptr
        vecs[0]  = '{6'b001000, 1'b0, 1'b0, 6'b001000, 3'd3, 1'b1, 1'b0, 3'd4};
        vecs[1]  = '{6'b001000, 1'b0, 1'b0, 6'b000000, 3'd3, 1'b0, 1'b1, 3'd4};
        vecs[2]  = '{6'b001000, 1'b0, 1'b0, 6'b001000, 3'd3, 1'b1, 1'b0, 3'd4};
        vecs[3]  = '{6'b000000, 1'b0, 1'b0, 6'b000000, 3'd3, 1'b0, 1'b0, 3'd4};
        vecs[4]  = '{6'b010000, 1'b0, 1'b0, 6'b010000, 3'd4, 1'b1, 1'b0, 3'd5};
        vecs[5]  = '{6'b100001, 1'b0, 1'b0, 6'b100000, 3'd5, 1'b1, 1'b0, 3'd0};
        vecs[6]  = '{6'b100001, 1'b0, 1'b0, 6'b000001, 3'd0, 1'b1, 1'b0, 3'd1};
        vecs[7]  = '{6'b100001, 1'b0, 1'b0, 6'b100000, 3'd5, 1'b1, 1'b0, 3'd0};
        vecs[8]  = '{6'b100001, 1'b0, 1'b0, 6'b000001, 3'd0, 1'b1, 1'b0, 3'd1};
        vecs[9]  = '{6'b000000, 1'b0, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b0, 3'd1};
        vecs[10] = '{6'b000110, 1'b1, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b1, 3'd1};
        vecs[11] = '{6'b000110, 1'b1, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b1, 3'd1};
        vecs[12] = '{6'b000110, 1'b1, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b1, 3'd1};
        vecs[13] = '{6'b000110, 1'b0, 1'b0, 6'b000010, 3'd1, 1'b1, 1'b0, 3'd2};
        vecs[14] = '{6'b000100, 1'b0, 1'b0, 6'b000100, 3'd2, 1'b1, 1'b0, 3'd3};
        vecs[15] = '{6'b000000, 1'b0, 1'b0, 6'b000000, 3'd2, 1'b0, 1'b0, 3'd3};
        vecs[16] = '{6'b000001, 1'b0, 1'b0, 6'b000001, 3'd0, 1'b1, 1'b0, 3'd1};
        vecs[17] = '{6'b000010, 1'b1, 1'b0, 6'b000000, 3'd0, 1'b0, 1'b1, 3'd1};
        vecs[18] = '{6'b000010, 1'b1, 1'b1, 6'b000000, 3'd0, 1'b0, 1'b1, 3'd1};
        vecs[19] = '{6'b000010, 1'b0, 1'b0, 6'b000010, 3'd1, 1'b1, 1'b0, 3'd2};
        vecs[20] = '{6'b100000, 1'b0, 1'b1, 6'b000000, 3'd1, 1'b0, 1'b1, 3'd2};
        vecs[21] = '{6'b100000, 1'b0, 1'b0, 6'b100000, 3'd5, 1'b1, 1'b0, 3'd0};
        vecs[22] = '{6'b000000, 1'b0, 1'b0, 6'b000000, 3'd5, 1'b0, 1'b0, 3'd0};

        // Reset with every source requesting.
        reset       = 1'b0;
        u_if.req    = 6'b111111;
        u_if.stall  = 1'b0;
        u_if.flush  = 1'b0;
        #3;
        chk_all("rst_async", 6'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        step();
        step();
        chk_all("rst_clocked", 6'b0, 3'd0, 1'b0, 1'b0, 3'd0);

        // First edge after release arms, second edge grants.
        reset = 1'b1;
        step();
        chk_all("rel_edge1", 6'b0, 3'd0, 1'b0, 1'b1, 3'd0);
        step();
        chk_all("rel_edge2", 6'b000001, 3'd0, 1'b1, 1'b0, 3'd1);
        u_if.req = 6'b000000;
        step();
        chk_all("rel_idle", 6'b0, 3'd0, 1'b0, 1'b0, 3'd1);

        for (int i = 0; i < 23; i++) begin
            u_if.req   = vecs[i].req;
            u_if.stall = vecs[i].stall;
            u_if.flush = vecs[i].flush;
            step();
            chk_all($sformatf("row%0d", i), vecs[i].gnt, vecs[i].sel,
                    vecs[i].rw, vecs[i].busy, vecs[i].ptr);
        end

        // Reset asserted while HI holds the grant; outputs drop before the next edge.
        u_if.req   = 6'b010000;
        u_if.stall = 1'b0;
        u_if.flush = 1'b0;
        step();
        chk_all("mid_grant", 6'b010000, 3'd4, 1'b1, 1'b0, 3'd5);
        #2;
        reset = 1'b0;
        #1;
        chk_all("mid_rst", 6'b0, 3'd0, 1'b0, 1'b0, 3'd0);
        step();
        reset = 1'b1;
        step();
        chk_all("rerel_edge1", 6'b0, 3'd0, 1'b0, 1'b1, 3'd0);
        step();
        chk_all("rerel_edge2", 6'b010000, 3'd4, 1'b1, 1'b0, 3'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
